// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: recovers pixel coordinates from sync/blank,
// validates line and frame geometry, checksums each frame and tracks lock.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC_W    = 96,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank_n,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [23:0] pixel_color,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        locked,
    output logic        timing_err,
    output logic [3:0]  err_flags,
    output logic [7:0]  err_count
);

    localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
    localparam logic [7:0]  H_SYNC_C   = 8'(H_SYNC_W);
    localparam logic [9:0]  H_ACTIVE_C = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
    localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic        hs_q, hs_d, vs_q, vs_d, bn_q, bn_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [7:0]  hs_w_q, hs_w_d;
    logic [9:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, line_cnt_q, line_cnt_d;
    logic [15:0] sum_acc_q, sum_acc_d;
    logic        h_armed_q, h_armed_d, frame_err_q, frame_err_d;
    logic [3:0]  good_q, good_d;
    logic        pixel_valid_q, pixel_valid_d, frame_done_q, frame_done_d;
    logic [9:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic [23:0] pixel_color_q, pixel_color_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic        locked_q, locked_d, timing_err_q, timing_err_d;
    logic [3:0]  err_flags_q, err_flags_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        hs_fall_s, hs_rise_s, vs_fall_s, bn_fall_s, chk_s, valid_s;
    logic        any_err_s, frame_clean_s;
    logic [3:0]  err_s;
    logic [9:0]  x_base_s;
    logic [15:0] pix_sum_s;

    // Edge detection, timing checks, counters, FSM and output staging.
    always_comb begin
        hs_d      = hsync;
        vs_d      = vsync;
        bn_d      = blank_n;
        hs_fall_s = hs_q & ~hsync;
        hs_rise_s = ~hs_q & hsync;
        vs_fall_s = vs_q & ~vsync;
        bn_fall_s = bn_q & ~blank_n;
        chk_s     = (state_q != ST_SEARCH);
        valid_s   = blank_n & chk_s;
        x_base_s  = hs_fall_s ? 10'd0 : x_cnt_q;
        pix_sum_s = 16'(red) + 16'(green) + 16'(blue);

        err_s    = 4'd0;
        err_s[0] = chk_s & h_armed_q & hs_fall_s & ((h_cnt_q + 11'd1) != H_TOTAL_C);
        err_s[1] = chk_s & hs_rise_s & (hs_w_q != H_SYNC_C);
        err_s[2] = chk_s & bn_fall_s & (x_cnt_q != H_ACTIVE_C);
        err_s[3] = chk_s & vs_fall_s & ((line_cnt_q != V_TOTAL_C) | (y_cnt_q != V_ACTIVE_C));
        any_err_s     = |err_s;
        frame_clean_s = ~frame_err_q & ~any_err_s;

        h_cnt_d   = hs_fall_s ? 11'd0 : sat_inc11(h_cnt_q);
        hs_w_d    = hsync ? 8'd0 : sat_inc8(hs_w_q);
        x_cnt_d   = blank_n ? sat_inc10(x_base_s) : x_base_s;
        h_armed_d = h_armed_q | hs_fall_s;

        // A pixel or hsync fall coincident with vsync fall belongs to the new frame.
        if (vs_fall_s) begin
            y_cnt_d     = 10'd0;
            line_cnt_d  = hs_fall_s ? 10'd1 : 10'd0;
            sum_acc_d   = valid_s ? pix_sum_s : 16'd0;
            frame_err_d = 1'b0;
        end else begin
            y_cnt_d     = bn_fall_s ? sat_inc10(y_cnt_q) : y_cnt_q;
            line_cnt_d  = hs_fall_s ? sat_inc10(line_cnt_q) : line_cnt_q;
            sum_acc_d   = valid_s ? (sum_acc_q + pix_sum_s) : sum_acc_q;
            frame_err_d = frame_err_q | any_err_s;
        end

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall_s) begin
                    state_d = ST_SYNC;
                    good_d  = 4'd0;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SYNC: begin
                if (vs_fall_s && frame_clean_s) begin
                    if ((good_q + 4'd1) >= LOCK_C) begin
                        state_d = ST_LOCKED;
                        good_d  = LOCK_C;
                    end else begin
                        good_d  = good_q + 4'd1;
                    end
                end else if (vs_fall_s) begin
                    good_d = 4'd0;
                end else begin
                    good_d = good_q;
                end
            end
            ST_LOCKED: begin
                if (any_err_s) begin
                    state_d = ST_SYNC;
                    good_d  = 4'd0;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = 4'd0;
            end
        endcase

        pixel_valid_d = valid_s;
        pixel_x_d     = valid_s ? x_base_s : 10'd0;
        pixel_y_d     = valid_s ? y_cnt_q : 10'd0;
        pixel_color_d = valid_s ? {red, green, blue} : 24'd0;
        frame_done_d  = vs_fall_s & chk_s;
        frame_sum_d   = frame_done_d ? sum_acc_q : frame_sum_q;
        locked_d      = (state_q == ST_LOCKED);
        timing_err_d  = any_err_s;
        err_flags_d   = err_flags_q | err_s;
        err_count_d   = any_err_s ? sat_inc8(err_count_q) : err_count_q;
    end

    // State and output registers; previous-sample flops reset high so no edge fires on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            bn_q          <= 1'b1;
            h_cnt_q       <= 11'd0;
            hs_w_q        <= 8'd0;
            x_cnt_q       <= 10'd0;
            y_cnt_q       <= 10'd0;
            line_cnt_q    <= 10'd0;
            sum_acc_q     <= 16'd0;
            h_armed_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            good_q        <= 4'd0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            pixel_color_q <= 24'd0;
            frame_done_q  <= 1'b0;
            frame_sum_q   <= 16'd0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            err_flags_q   <= 4'd0;
            err_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            bn_q          <= bn_d;
            h_cnt_q       <= h_cnt_d;
            hs_w_q        <= hs_w_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            line_cnt_q    <= line_cnt_d;
            sum_acc_q     <= sum_acc_d;
            h_armed_q     <= h_armed_d;
            frame_err_q   <= frame_err_d;
            good_q        <= good_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_color_q <= pixel_color_d;
            frame_done_q  <= frame_done_d;
            frame_sum_q   <= frame_sum_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_d;
            err_flags_q   <= err_flags_d;
            err_count_q   <= err_count_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_color = pixel_color_q;
    assign frame_done  = frame_done_q;
    assign frame_sum   = frame_sum_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
    assign err_flags   = err_flags_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down geometry
// (8x4 active, 16 clk lines, 6 lines per frame) so every scenario stays short.
module tb_vga_sync_decoder;

    localparam int HA = 8;
    localparam int HT = 16;
    localparam int HW = 3;
    localparam int VA = 4;
    localparam int VT = 6;
    localparam int LF = 2;
    localparam int ACT_START = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        blank_n = 1'b0;
    logic [7:0]  red = 8'd0;
    logic [7:0]  green = 8'd0;
    logic [7:0]  blue = 8'd0;
    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [23:0] pixel_color;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic        locked;
    logic        timing_err;
    logic [3:0]  err_flags;
    logic [7:0]  err_count;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_W(HW),
        .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .red(red), .green(green), .blue(blue),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_color(pixel_color), .frame_done(frame_done), .frame_sum(frame_sum),
        .locked(locked), .timing_err(timing_err), .err_flags(err_flags),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int pv_cnt = 0;
    int fd_cnt = 0;
    int te_cnt = 0;
    int coord_bad = 0;
    int cur_x = 0;
    int cur_y = 0;
    int first_x = -1;
    int first_y = -1;
    int last_x = -1;
    int last_y = -1;
    logic [15:0] fd_sum = 16'd0;
    logic [15:0] model_acc = 16'd0;
    logic [15:0] model_prev = 16'd0;
    logic te_prev = 1'b0;
    logic lk_at = 1'b0;
    logic lk_after = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: the DUT samples the driven inputs, outputs are observed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pixel_valid) begin
            if (pv_cnt == 0) begin
                first_x = int'(pixel_x);
                first_y = int'(pixel_y);
            end
            last_x = int'(pixel_x);
            last_y = int'(pixel_y);
            pv_cnt++;
            if (int'(pixel_x) != cur_x || int'(pixel_y) != cur_y || pixel_color != {red, green, blue})
                coord_bad++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_sum = frame_sum;
        end
        if (te_prev) lk_after = locked;
        if (timing_err) begin
            te_cnt++;
            lk_at = locked;
        end
        te_prev = timing_err;
    endtask

    task automatic drive_line(input int len, input int sw, input int act, input bit vlow,
                              input bit is_act, input int yy, input bit ones);
        for (int c = 0; c < len; c++) begin
            hsync = (c < sw) ? 1'b0 : 1'b1;
            vsync = vlow ? 1'b0 : 1'b1;
            if (is_act && c >= ACT_START && c < ACT_START + act) begin
                blank_n = 1'b1;
                cur_x   = c - ACT_START;
                cur_y   = yy;
                red     = ones ? 8'd1 : 8'(cur_x * 16 + cur_y);
                green   = ones ? 8'd1 : 8'(200 + cur_x);
                blue    = ones ? 8'd1 : 8'(cur_y * 50 + 7);
                model_acc = model_acc + 16'(red) + 16'(green) + 16'(blue);
            end else begin
                blank_n = 1'b0;
                red     = 8'd0;
                green   = 8'd0;
                blue    = 8'd0;
            end
            tick();
        end
    endtask

    // Vsync low on lines 0-1, active video on lines 2 and up; one line may be distorted.
    task automatic drive_frame(input int nlines, input bit ones, input int bad_line,
                               input int bad_len, input int bad_sw, input int bad_act);
        int len;
        int sw;
        int act;
        model_prev = model_acc;
        model_acc  = 16'd0;
        pv_cnt     = 0;
        coord_bad  = 0;
        for (int l = 0; l < nlines; l++) begin
            len = HT;
            sw  = HW;
            act = HA;
            if (l == bad_line) begin
                len = bad_len;
                sw  = bad_sw;
                act = bad_act;
            end
            drive_line(len, sw, act, l < 2, l >= 2, l - 2, ones);
        end
    endtask

    task automatic clean_frame(input bit ones);
        drive_frame(VT, ones, -1, HT, HW, HA);
    endtask

    initial begin
        repeat (3) tick();
        check_eq("rst_pixel_valid", pixel_valid, 0);
        check_eq("rst_pixel_x", pixel_x, 0);
        check_eq("rst_pixel_y", pixel_y, 0);
        check_eq("rst_pixel_color", pixel_color, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_frame_sum", frame_sum, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_timing_err", timing_err, 0);
        check_eq("rst_err_flags", err_flags, 0);
        check_eq("rst_err_count", err_count, 0);
        rst = 1'b1;

        pv_cnt = 0;
        repeat (3) drive_line(HT, HW, HA, 1'b0, 1'b1, 0, 1'b0);
        check_eq("search_no_valid", pv_cnt, 0);

        clean_frame(1'b1);
        check_eq("a_valid_count", pv_cnt, 32);
        check_eq("a_coords", coord_bad, 0);
        check_eq("a_no_frame_done", fd_cnt, 0);

        clean_frame(1'b1);
        check_eq("b_frame_done", fd_cnt, 1);
        check_eq("b_frame_sum", fd_sum, 16'h0060);
        check_eq("b_not_locked", locked, 0);

        clean_frame(1'b0);
        check_eq("c_locked", locked, 1);
        check_eq("c_frame_sum", fd_sum, 16'h0060);
        check_eq("c_first_x", first_x, 0);
        check_eq("c_first_y", first_y, 0);
        check_eq("c_last_x", last_x, HA - 1);
        check_eq("c_last_y", last_y, VA - 1);
        check_eq("c_valid_count", pv_cnt, 32);
        check_eq("c_coords", coord_bad, 0);
        check_eq("c_err_count", err_count, 0);

        te_cnt = 0;
        drive_frame(VT, 1'b0, 3, HT - 1, HW, HA);
        check_eq("d_err_pulses", te_cnt, 1);
        check_eq("d_err_flags", err_flags, 4'h1);
        check_eq("d_err_count", err_count, 1);
        check_eq("d_locked_at_err", lk_at, 1);
        check_eq("d_locked_after_err", lk_after, 0);

        clean_frame(1'b0);
        check_eq("e_frame_sum", fd_sum, model_prev);
        clean_frame(1'b0);
        check_eq("f_not_locked", locked, 0);
        clean_frame(1'b0);
        check_eq("g_relocked", locked, 1);
        check_eq("g_err_pulses", te_cnt, 1);

        drive_frame(VT, 1'b0, 2, HT, HW - 1, HA);
        check_eq("h_err_flags", err_flags, 4'h3);
        check_eq("h_err_count", err_count, 2);
        drive_frame(VT, 1'b0, 3, HT, HW, HA - 1);
        check_eq("i_err_flags", err_flags, 4'h7);
        check_eq("i_err_count", err_count, 3);
        drive_frame(VT - 1, 1'b0, -1, HT, HW, HA);
        fd_cnt = 0;
        clean_frame(1'b0);
        check_eq("k_err_flags", err_flags, 4'hF);
        check_eq("k_err_count", err_count, 4);
        check_eq("k_frame_done", fd_cnt, 1);
        check_eq("k_short_frame_sum", fd_sum, model_prev);

        model_acc = 16'd0;
        drive_line(HT, HW, HA, 1'b1, 1'b0, 0, 1'b0);
        drive_line(HT, HW, HA, 1'b1, 1'b0, 0, 1'b0);
        drive_line(HT, HW, HA, 1'b0, 1'b1, 0, 1'b0);
        drive_line(ACT_START + 3, HW, HA, 1'b0, 1'b1, 1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", pixel_valid, 0);
        check_eq("mid_rst_x", pixel_x, 0);
        check_eq("mid_rst_frame_sum", frame_sum, 0);
        check_eq("mid_rst_err_flags", err_flags, 0);
        check_eq("mid_rst_err_count", err_count, 0);
        hsync = 1'b1;
        vsync = 1'b1;
        blank_n = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        pv_cnt = 0;
        fd_cnt = 0;
        repeat (3) drive_line(HT, HW, HA, 1'b0, 1'b1, 0, 1'b0);
        check_eq("post_rst_no_valid", pv_cnt, 0);
        check_eq("post_rst_no_done", fd_cnt, 0);
        check_eq("post_rst_locked", locked, 0);
        clean_frame(1'b0);
        check_eq("m_no_frame_done", fd_cnt, 0);
        clean_frame(1'b0);
        check_eq("n_frame_done", fd_cnt, 1);
        check_eq("n_frame_sum", fd_sum, model_prev);
        check_eq("n_err_count", err_count, 0);

        te_cnt = 0;
        repeat (300) drive_line(HT - 1, HW, 0, 1'b0, 1'b0, 0, 1'b0);
        check_eq("sat_err_count", err_count, 8'd255);
        check_eq("sat_err_pulses", te_cnt, 299);
        check_eq("sat_err_flags", err_flags, 4'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA driver. Samples the driver's hsync/vsync/blank and RGB outputs on the pixel clock, recovers pixel coordinates, and checks line and frame timing against 640x480@60 geometry. Computes a per-frame pixel checksum and reports lock status and timing errors. Used as an on-chip self-check and as the bench's frame monitor for the game display path.

Parameters:
H_ACTIVE, 640, active pixels per line
H_TOTAL, 800, clocks per line (hsync fall to hsync fall)
H_SYNC_W, 96, hsync low width in clocks
V_ACTIVE, 480, active lines per frame
V_TOTAL, 525, hsync falls per frame (vsync fall to vsync fall)
LOCK_FRAMES, 2, consecutive error-free frames required for lock

Ports:
clk  in  1  25 MHz pixel clock, same clock that drives the VGA driver
rst  in  1  asynchronous, active-low reset
hsync  in  1  horizontal sync, active-low
vsync  in  1  vertical sync, active-low
blank_n  in  1  1 = active video, 0 = blanking
red/green/blue  in  8 each  pixel colour
pixel_valid  out  1  registered active-pixel strobe
pixel_x  out  10  x of current pixel, 0..H_ACTIVE-1
pixel_y  out  10  y of current pixel, 0..V_ACTIVE-1
pixel_color  out  24  {red,green,blue} of current pixel
frame_done  out  1  one-cycle pulse at each frame boundary once synced
frame_sum  out  16  checksum of the last completed frame
locked  out  1  timing locked
timing_err  out  1  one-cycle pulse on any detected error
err_flags  out  4  sticky error causes: [0] line length, [1] hsync width, [2] active width, [3] frame lines / active lines
err_count  out  8  saturating error count

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state SEARCH, all counters 0, previous-sample registers 1 (no false edge detected after release).
- Edges: every input is registered once. An edge is the registered value compared with the current sample. Output latency is 1 clk from the sampling edge.
- h_cnt (11 b, saturating at 2047): cleared on hsync fall, otherwise increments. At each hsync fall, h_cnt+1 != H_TOTAL sets flag[0]. The first fall after SEARCH is not checked.
- hs_w (8 b, saturating): counts clocks while hsync is low. On hsync rise, hs_w != H_SYNC_W sets flag[1].
- x_cnt: cleared on hsync fall, increments each blank_n=1 clock. pixel_x = x_cnt before the increment.
- On a blank_n fall, x_cnt != H_ACTIVE sets flag[2], and y_cnt increments (10 b, saturating).
- line_cnt: counts hsync falls within a frame.
- An hsync fall in the same clk as a vsync fall counts as line 0 of the new frame.
- pixel_valid=1 only when blank_n=1 and state != SEARCH. pixel_color is {r,g,b} of the same sample.
- sum_acc (16 b, wraps): adds red+green+blue on every valid pixel.
- At a vsync fall, line_cnt != V_TOTAL or y_cnt != V_ACTIVE sets flag[3]. The frame is then closed: frame_sum <= sum_acc, frame_done pulses, and sum_acc, y_cnt and line_cnt are cleared.
- Error handling: any flag set in a cycle pulses timing_err and increments err_count (saturating at 255). err_flags is sticky until reset. Multiple causes in one cycle count once.
- FSM:
  - SEARCH: wait for the first vsync fall, then go to SYNC with good=0. No checks, no frame_done.
  - SYNC: at each vsync fall, good++ if the frame was error-free, else good=0. When good reaches LOCK_FRAMES, go to LOCKED and assert locked.
  - LOCKED: any timing_err returns to SYNC with good=0. locked drops on the next clk.
- Reset mid-frame: immediate return to SEARCH. No partial frame_sum is ever reported.
- No coordinate wrap: if blank_n exceeds the nominal active region, counters saturate and the error path flags it.

Test Plan:
- Nominal frames, RGB=(1,1,1) every active pixel -> frame_done on 2nd vsync fall with frame_sum=0x1000 (921600 mod 65536); locked=1 after the 3rd vsync fall; err_count=0.
- Coordinates -> first valid pixel of a frame has x=0,y=0; last has x=639,y=479; 307200 pixel_valid pulses per frame.
- While locked, one line of 799 clks -> timing_err pulse, err_flags[0]=1, err_count=1, locked=0 next clk; locked returns after 2 clean frames.
- hsync low for 95 clks -> err_flags[1]=1. One line with 639 active pixels -> err_flags[2]=1 at the blank_n fall.
- Frame with 524 lines -> err_flags[3]=1 at the vsync fall; frame_done still pulses with that frame's sum.
- Assert rst mid-frame, release -> all outputs 0, no pixel_valid until a vsync fall; 300 forced errors -> err_count saturates at 255.
